// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared constants for the PS/2 mouse controller: device command/response
// bytes, cursor word width and the init/stream FSM state encoding.
package ps2_mouse_ctrl_pkg;

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;
   localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
   localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
   localparam logic [7:0] RSP_ID      = 8'h00;

   localparam int POS_W = 10;

   typedef enum logic [3:0] {
      RST_SEND,
      RST_WAIT,
      RST_ACK,
      BAT,
      ID,
      EN_SEND,
      EN_WAIT,
      EN_ACK,
      STREAM,
      FAIL
   } state_t;

endpackage

// File: rtl/ps2_mouse_ctrl_if.sv
// PHY byte handshake plus CPU read port of the mouse controller.
// master = controller side, slave = PHY/CPU environment side.
interface ps2_mouse_ctrl_if;

   logic [7:0]  tx_byte;
   logic        tx_start;
   logic        tx_done;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        io_cs;
   logic        addr;
   logic [15:0] data_out;
   logic        RDA;
   logic        ready;
   logic        err;

   modport master (
      output tx_byte, tx_start, data_out, RDA, ready, err,
      input  tx_done, rx_byte, rx_valid, io_cs, addr
   );

   modport slave (
      input  tx_byte, tx_start, data_out, RDA, ready, err,
      output tx_done, rx_byte, rx_valid, io_cs, addr
   );

endinterface

// File: rtl/ps2_mouse_ctrl_pos_accum.sv
// One cursor axis: 9-bit signed delta decode with overflow masking,
// optional negation (screen Y grows downward) and clamp to [0, MAX].
module ps2_mouse_ctrl_pos_accum
   import ps2_mouse_ctrl_pkg::*;
#(
   parameter int MAX = 639,
   parameter int NEG = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_p0,
   input  logic             ovf,
   input  logic             sgn,
   input  logic [7:0]       mag,
   output logic [POS_W-1:0] pos
);

   localparam logic signed [11:0] MAX_S = 12'(MAX);

   logic signed [11:0] delta;
   logic signed [11:0] step;
   logic signed [11:0] sum;

   function automatic logic [POS_W-1:0] clamp_pos(input logic signed [11:0] v);
      if (v < 0)
         return '0;
      if (v > MAX_S)
         return POS_W'(MAX);
      return v[POS_W-1:0];
   endfunction

   always_comb begin
      delta = ovf ? '0 : {{4{sgn}}, mag};
      step  = (NEG != 0) ? -delta : delta;
      sum   = $signed(12'(pos)) + step;
   end

   // stage p1: position register, one cycle after the decoded packet
   always_ff @(posedge clk) begin
      if (!rst)
         pos <= POS_W'(MAX / 2);
      else if (vld_p0)
         pos <= clamp_pos(sum);
   end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: reset/enable init sequence with retries and timeout,
// 3-byte stream packet framing, clamped cursor accumulation and CPU read mux.
module ps2_mouse_ctrl
   import ps2_mouse_ctrl_pkg::*;
#(
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479,
   parameter int TIMEOUT_CYC = 12_500_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic             clk,
   input  logic             rst,
   ps2_mouse_ctrl_if.master bus
);

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [RTY_W-1:0] retry;
   logic             tx_start_q;
   logic [7:0]       tx_byte_q;
   logic             ready_q;
   logic             err_q;

   logic             waiting;
   logic             en_phase;
   logic             adv;
   logic             nack;
   logic             timeout;
   logic             retry_req;

   logic [1:0]       idx;
   logic [3:0]       pkt_flags;
   logic [2:0]       pkt_btn;
   logic [7:0]       pkt_dx;
   logic             vld_p0;
   logic [3:0]       flags_p0;
   logic [2:0]       btn_p0;
   logic [7:0]       dx_p0;
   logic [7:0]       dy_p0;
   logic [2:0]       btn;
   logic             rda_q;
   logic [POS_W-1:0] pos_x;
   logic [POS_W-1:0] pos_y;

   // A valid advancing response always wins over a timeout in the same cycle.
   always_comb begin
      waiting  = 1'b0;
      en_phase = 1'b0;
      adv      = 1'b0;
      nack     = 1'b0;
      case (state)
         RST_WAIT: begin
            waiting = 1'b1;
            adv     = bus.tx_done;
         end
         RST_ACK: begin
            waiting = 1'b1;
            adv     = bus.rx_valid && (bus.rx_byte == RSP_ACK);
            nack    = bus.rx_valid && (bus.rx_byte == RSP_RESEND);
         end
         BAT: begin
            waiting = 1'b1;
            adv     = bus.rx_valid && (bus.rx_byte == RSP_BAT_OK);
            nack    = bus.rx_valid && (bus.rx_byte == RSP_BAT_ERR);
         end
         ID: begin
            waiting = 1'b1;
            adv     = bus.rx_valid && (bus.rx_byte == RSP_ID);
         end
         EN_WAIT: begin
            waiting  = 1'b1;
            en_phase = 1'b1;
            adv      = bus.tx_done;
         end
         EN_ACK: begin
            waiting  = 1'b1;
            en_phase = 1'b1;
            adv      = bus.rx_valid && (bus.rx_byte == RSP_ACK);
            nack     = bus.rx_valid && (bus.rx_byte == RSP_RESEND);
         end
         default: ;
      endcase
      timeout   = waiting && (timer == TMR_W'(TIMEOUT_CYC - 1));
      retry_req = !adv && (nack || timeout);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RST_SEND;
         timer      <= '0;
         retry      <= '0;
         tx_start_q <= 1'b0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         timer      <= waiting ? timer + 1'b1 : '0;
         if (retry_req) begin
            timer <= '0;
            if (retry >= RTY_W'(MAX_RETRY)) begin
               state <= FAIL;
               err_q <= 1'b1;
            end else begin
               retry <= retry + 1'b1;
               state <= en_phase ? EN_SEND : RST_SEND;
            end
         end else if (adv) begin
            timer <= '0;
            case (state)
               RST_WAIT: state <= RST_ACK;
               RST_ACK:  state <= BAT;
               BAT:      state <= ID;
               ID: begin
                  state <= EN_SEND;
                  retry <= '0;
               end
               EN_WAIT:  state <= EN_ACK;
               EN_ACK: begin
                  state   <= STREAM;
                  ready_q <= 1'b1;
               end
               default: ;
            endcase
         end else begin
            case (state)
               RST_SEND: begin
                  tx_start_q <= 1'b1;
                  state      <= RST_WAIT;
               end
               EN_SEND: begin
                  tx_start_q <= 1'b1;
                  state      <= EN_WAIT;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == RST_SEND)
         tx_byte_q <= CMD_RESET;
      else if (state == EN_SEND)
         tx_byte_q <= CMD_ENABLE;
   end

   // Framer control: bytes without bit3 at position 0 are dropped to resync.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx    <= '0;
         vld_p0 <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         if (state == STREAM && bus.rx_valid) begin
            case (idx)
               2'd0:    if (bus.rx_byte[3]) idx <= 2'd1;
               2'd1:    idx <= 2'd2;
               default: begin
                  idx    <= 2'd0;
                  vld_p0 <= 1'b1;
               end
            endcase
         end
      end
   end

   // stage p0: complete packet snapshot handed to the axis accumulators
   always_ff @(posedge clk) begin
      if (state == STREAM && bus.rx_valid) begin
         case (idx)
            2'd0: begin
               pkt_flags <= bus.rx_byte[7:4];
               pkt_btn   <= bus.rx_byte[2:0];
            end
            2'd1:    pkt_dx <= bus.rx_byte;
            default: begin
               flags_p0 <= pkt_flags;
               btn_p0   <= pkt_btn;
               dx_p0    <= pkt_dx;
               dy_p0    <= bus.rx_byte;
            end
         endcase
      end
   end

   ps2_mouse_ctrl_pos_accum #(.MAX(X_MAX), .NEG(0)) u_acc_x (
      .clk    (clk),
      .rst    (rst),
      .vld_p0 (vld_p0),
      .ovf    (flags_p0[2]),
      .sgn    (flags_p0[0]),
      .mag    (dx_p0),
      .pos    (pos_x)
   );

   ps2_mouse_ctrl_pos_accum #(.MAX(Y_MAX), .NEG(1)) u_acc_y (
      .clk    (clk),
      .rst    (rst),
      .vld_p0 (vld_p0),
      .ovf    (flags_p0[3]),
      .sgn    (flags_p0[1]),
      .mag    (dy_p0),
      .pos    (pos_y)
   );

   // A packet landing in the same cycle as a Y-word read keeps RDA set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         btn   <= '0;
         rda_q <= 1'b0;
      end else if (vld_p0) begin
         btn   <= btn_p0;
         rda_q <= 1'b1;
      end else if (bus.io_cs && bus.addr) begin
         rda_q <= 1'b0;
      end
   end

   always_comb begin
      bus.data_out = '0;
      if (bus.io_cs)
         bus.data_out = bus.addr ? {3'b0, btn, pos_y} : {6'b0, pos_x};
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_byte  = tx_byte_q;
   assign bus.RDA      = rda_q;
   assign bus.ready    = ready_q;
   assign bus.err      = err_q;

endmodule
